// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline register.
package pipe_pkg;

    // Holding state of the pipeline register; S_FULL keeps both flops in use.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_BUSY  = 2'b01,
        S_FULL  = 2'b11
    } skid_state_t;

    // Number of words the block can hold (main plus skid).
    localparam logic [1:0] SKID_DEPTH = 2'd2;

    // Number of held words implied by a state; unknown encodings read as empty.
    function automatic logic [1:0] occ_of(input skid_state_t st);
        logic [1:0] occ;
        case (st)
            S_EMPTY: occ = 2'd0;
            S_BUSY:  occ = 2'd1;
            S_FULL:  occ = SKID_DEPTH;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/flopenr_n.sv
// N-bit register with load enable, asynchronous active-low reset to zero
// and a synchronous clear that takes priority over the enable.
module flopenr_n #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // Storage flop: clear wins over load, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/skid_pipe_reg.sv
// Elastic pipeline register: one-cycle latency, two-word capacity, with
// in_ready/out_valid/occupancy held in flops so no input reaches them
// combinationally. flush squashes everything synchronously.
module skid_pipe_reg
    import pipe_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [1:0]   occupancy
);

    skid_state_t  state_r;
    skid_state_t  state_next_s;
    logic         in_ready_r;
    logic         out_valid_r;
    logic [1:0]   occupancy_r;

    logic         in_xfer_s;
    logic         out_xfer_s;
    logic         main_en_s;
    logic         skid_en_s;
    logic         main_from_skid_s;
    logic [N-1:0] main_d_s;
    logic [N-1:0] main_q_s;
    logic [N-1:0] skid_q_s;

    // Handshake decode and main-register source select.
    always_comb begin
        in_xfer_s  = in_valid && in_ready_r;
        out_xfer_s = out_valid_r && out_ready;
        if (main_from_skid_s) begin
            main_d_s = skid_q_s;
        end else begin
            main_d_s = in_data;
        end
    end

    // Next-state and register load control; flush overrides every other rule.
    always_comb begin
        state_next_s     = state_r;
        main_en_s        = 1'b0;
        skid_en_s        = 1'b0;
        main_from_skid_s = 1'b0;
        if (flush) begin
            state_next_s = S_EMPTY;
        end else begin
            case (state_r)
                S_EMPTY: begin
                    if (in_xfer_s) begin
                        main_en_s    = 1'b1;
                        state_next_s = S_BUSY;
                    end else begin
                        state_next_s = S_EMPTY;
                    end
                end
                S_BUSY: begin
                    if (in_xfer_s && out_xfer_s) begin
                        main_en_s    = 1'b1;
                        state_next_s = S_BUSY;
                    end else if (in_xfer_s) begin
                        skid_en_s    = 1'b1;
                        state_next_s = S_FULL;
                    end else if (out_xfer_s) begin
                        state_next_s = S_EMPTY;
                    end else begin
                        state_next_s = S_BUSY;
                    end
                end
                S_FULL: begin
                    if (out_xfer_s) begin
                        main_en_s        = 1'b1;
                        main_from_skid_s = 1'b1;
                        state_next_s     = S_BUSY;
                    end else begin
                        state_next_s = S_FULL;
                    end
                end
                default: begin
                    state_next_s = S_EMPTY;
                end
            endcase
        end
    end

    // State register plus flopped status outputs derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= S_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            occupancy_r <= 2'd0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s != S_FULL);
            out_valid_r <= (state_next_s != S_EMPTY);
            occupancy_r <= occ_of(state_next_s);
        end
    end

    flopenr_n #(.N(N)) u_main (
        .clk   (clk),
        .reset (reset),
        .en    (main_en_s),
        .clr   (flush),
        .d     (main_d_s),
        .q     (main_q_s)
    );

    flopenr_n #(.N(N)) u_skid (
        .clk   (clk),
        .reset (reset),
        .en    (skid_en_s),
        .clr   (flush),
        .d     (in_data),
        .q     (skid_q_s)
    );

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign occupancy = occupancy_r;
    assign out_data  = main_q_s;

endmodule

// File: doc/skid_pipe_reg.md
# skid_pipe_reg

Elastic pipeline register that replaces a plain reset flip-flop between two datapath stages when the downstream stage can stall. It accepts an N-bit word on a valid/ready handshake, presents it one cycle later, and holds up to two words through a main register and a skid register. Because `in_ready` is fully registered, the stall path between stages is cut and the block can sit anywhere in the pipeline without lengthening a combinational ready chain. A synchronous flush empties it for branch or exception squashing.

## Interface
- `N`, 32, data width in bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous squash; discards all held words.
- `in_valid`  in  1  upstream word present on `in_data`.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_data`  in  N  upstream word.
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_ready`  in  1  downstream accepts `out_data` this cycle.
- `out_data`  out  N  oldest held word.
- `occupancy`  out  2  number of held words, 0 to 2.

## Operation
- An input transfer occurs on an edge where `in_valid && in_ready`. An output transfer occurs on an edge where `out_valid && out_ready`.
- State machine:
  - S_EMPTY: `out_valid=0`, `in_ready=1`, `occupancy=0`.
  - S_BUSY: main register full, `out_valid=1`, `in_ready=1`, `occupancy=1`.
  - S_FULL: main and skid registers full, `out_valid=1`, `in_ready=0`, `occupancy=2`.
- Transitions, evaluated in priority order:
  - `flush=1`: go to S_EMPTY; main and skid registers load 0. Any input transfer that cycle is discarded. This rule overrides every rule below.
  - S_EMPTY with an input transfer: main loads `in_data`; go to S_BUSY.
  - S_BUSY with input and output transfers together: main loads `in_data`; stay in S_BUSY.
  - S_BUSY with an input transfer only: skid loads `in_data`; go to S_FULL.
  - S_BUSY with an output transfer only: go to S_EMPTY; main keeps its value.
  - S_FULL with an output transfer: main loads skid; go to S_BUSY. `in_ready=0` in S_FULL, so no input transfer can occur.
  - Any other case: hold state and data.
- `out_data` always shows the main register, including in S_EMPTY, where the value is don't-care to consumers.
- Word order is strictly FIFO. No word is ever dropped or duplicated except by `flush`.
- The `in_data` value is ignored when `in_valid=0`. Ignoring `out_ready` while `out_valid=0` is legal.
- Unreachable state encoding: recover to S_EMPTY on the next edge.

## Timing
- While `reset=0`, asynchronously: state is S_EMPTY, `out_valid=0`, `in_ready=1`, `out_data=0`, `occupancy=0`, and the skid register is 0.
- Reset asserted mid-operation discards all held words immediately, without waiting for a clock edge. The first transfer can occur on the first rising edge after `reset` returns to 1.
- Latency: a word accepted on edge k appears on `out_data` with `out_valid=1` after edge k, so it is available for output transfer at edge k+1.
- Throughput: one word per cycle sustained while `out_ready=1`.
- `in_ready`, `out_valid` and `occupancy` are decoded only from the state register, with no combinational path from any input.
- `flush` on the same edge as the release of a stall still empties the block. The downstream transfer of that edge counts as completed; the word leaves through the output.

## Structure
- Shared package `pipe_pkg` holds:
  - typedef `skid_state_t` (2-bit enum: S_EMPTY=2'b00, S_BUSY=2'b01, S_FULL=2'b11);
  - constant `SKID_DEPTH=2`.
- One sub-module, `flopenr_n`: an N-bit register with enable, asynchronous active-low reset to 0 and synchronous clear. It is instantiated twice, once for main and once for skid. The next-state logic lives in `skid_pipe_reg`.

## Test plan
- Reset and stream: assert `reset=0` for 3 cycles, then release with `out_ready=1`, feeding 10 `$random` words on consecutive cycles → each word appears one cycle after acceptance, in order, with `in_ready` always 1 and `occupancy` always 1 once streaming.
- Stall fill: `out_ready=0`, feed 32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003 → the first two are accepted, `occupancy=2`, `in_ready=0` and the third is held upstream. Raise `out_ready` → the block outputs 0001, 0002, 0003 on consecutive cycles.
- Flush in S_FULL with `in_valid=1` and `in_data=32'hDEAD_BEEF` → on the next cycle `out_valid=0`, `occupancy=0`, `out_data=0`, and DEADBEEF is never output.
- Asynchronous reset mid-stall: in S_FULL, pull `reset` low between edges → `out_valid=0` and `in_ready=1` before the next rising edge.
- Simultaneous transfers in S_BUSY holding 32'h1 with input 32'h2 → the block stays in S_BUSY and `out_data=32'h2` on the next cycle.
- Random `in_valid`/`out_ready` (50%) for 1000 cycles against a scoreboard queue → zero mismatches, with `occupancy` matching the queue depth.
